// File: rtl/native_arb_pkg.sv
// rtl/native_arb_pkg.sv - shared types and width helpers for the native port arbiter
package native_arb_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Width of a requester index (PTR_W); never narrower than one bit.
    function automatic int ptr_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    // Width of the WAIT counter, which counts 0 .. cycles-1.
    function automatic int timeout_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/native_rr_pick.sv
// rtl/native_rr_pick.sv - combinational round-robin picker
module native_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    int j;

    // Scan cyclically from ptr and take the first pending request.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        j            = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any             = 1'b1;
                grant_idx       = PTR_W'(j);
                grant_onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/native_port_arbiter.sv
// rtl/native_port_arbiter.sv - round-robin sharing of one native register port
// Optional WAIT timeout with error completion: define NATIVE_ARB_TIMEOUT_EN.
module native_port_arbiter
    import native_arb_pkg::*;
#(
    parameter int NUM_REQ           = 2,
    parameter int NATIVE_ADDR_WIDTH = 4,
    parameter int NATIVE_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                                   S_AXI_aclk,
    input  logic                                   S_AXI_aresetn,
    input  logic [NUM_REQ-1:0]                     REQ_VALID,
    input  logic [NUM_REQ-1:0]                     REQ_WR,
    input  logic [NUM_REQ*NATIVE_ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [NUM_REQ*NATIVE_DATA_WIDTH-1:0]   REQ_WDATA,
    output logic [NUM_REQ-1:0]                     REQ_READY,
    output logic [NUM_REQ-1:0]                     RSP_VALID,
    output logic [NATIVE_DATA_WIDTH-1:0]           RSP_RDATA,
    output logic                                   RSP_ERR,
    output logic                                   NATIVE_CLK,
    output logic                                   NATIVE_EN,
    output logic                                   NATIVE_WR,
    output logic [NATIVE_ADDR_WIDTH-1:0]           NATIVE_ADDR,
    output logic [NATIVE_DATA_WIDTH-1:0]           NATIVE_DATA_IN,
    input  logic [NATIVE_DATA_WIDTH-1:0]           NATIVE_DATA_OUT,
    input  logic                                   NATIVE_READY
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    arb_state_e                   state_q, state_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [PTR_W-1:0]             grant_q, grant_d;
    logic [NUM_REQ-1:0]           req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
    logic [NATIVE_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                         native_en_q, native_en_d;
    logic                         native_wr_q, native_wr_d;
    logic [NATIVE_ADDR_WIDTH-1:0] native_addr_q, native_addr_d;
    logic [NATIVE_DATA_WIDTH-1:0] native_data_q, native_data_d;

`ifdef NATIVE_ARB_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         rsp_err_q, rsp_err_d;
`endif

    logic [NUM_REQ-1:0]           pick_onehot;
    logic [PTR_W-1:0]             pick_idx;
    logic                         pick_any;

    native_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req          (REQ_VALID),
        .ptr          (ptr_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .any          (pick_any)
    );

    // Next-state and registered-output logic for one serialised transaction.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        req_ready_d   = '0;
        rsp_valid_d   = '0;
        rsp_rdata_d   = rsp_rdata_q;
        native_en_d   = 1'b0;
        native_wr_d   = native_wr_q;
        native_addr_d = native_addr_q;
        native_data_d = native_data_q;
`ifdef NATIVE_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_err_d     = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d       = pick_idx;
                    native_wr_d   = REQ_WR[pick_idx];
                    native_addr_d = REQ_ADDR[int'(pick_idx)*NATIVE_ADDR_WIDTH +: NATIVE_ADDR_WIDTH];
                    native_data_d = REQ_WDATA[int'(pick_idx)*NATIVE_DATA_WIDTH +: NATIVE_DATA_WIDTH];
                    req_ready_d   = pick_onehot;
                    native_en_d   = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                // The strobe is on the wire this cycle; slave ready is not yet meaningful.
`ifdef NATIVE_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (NATIVE_READY) begin
                    rsp_rdata_d          = native_wr_q ? '0 : NATIVE_DATA_OUT;
                    rsp_valid_d[grant_q] = 1'b1;
`ifdef NATIVE_ARB_TIMEOUT_EN
                    rsp_err_d            = 1'b0;
`endif
                    state_d              = RESP;
                end
`ifdef NATIVE_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d          = '0;
                    rsp_err_d            = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                ptr_d   = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            native_en_q   <= 1'b0;
            native_wr_q   <= 1'b0;
            native_addr_q <= '0;
            native_data_q <= '0;
`ifdef NATIVE_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            native_en_q   <= native_en_d;
            native_wr_q   <= native_wr_d;
            native_addr_q <= native_addr_d;
            native_data_q <= native_data_d;
`ifdef NATIVE_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            rsp_err_q     <= rsp_err_d;
`endif
        end
    end

    assign REQ_READY      = req_ready_q;
    assign RSP_VALID      = rsp_valid_q;
    assign RSP_RDATA      = rsp_rdata_q;
    assign NATIVE_CLK     = S_AXI_aclk;
    assign NATIVE_EN      = native_en_q;
    assign NATIVE_WR      = native_wr_q;
    assign NATIVE_ADDR    = native_addr_q;
    assign NATIVE_DATA_IN = native_data_q;
`ifdef NATIVE_ARB_TIMEOUT_EN
    assign RSP_ERR        = rsp_err_q;
`else
    assign RSP_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_native_port_arbiter.sv
// tb/tb_native_port_arbiter.sv - self-checking bench for native_port_arbiter
module tb_native_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            native_clk;
    logic            native_en;
    logic            native_wr;
    logic [AW-1:0]   native_addr;
    logic [DW-1:0]   native_data_in;
    logic [DW-1:0]   native_data_out;
    logic            native_ready = 1'b0;

    native_port_arbiter #(
        .NUM_REQ           (N),
        .NATIVE_ADDR_WIDTH (AW),
        .NATIVE_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .S_AXI_aclk      (clk),
        .S_AXI_aresetn   (rst_n),
        .REQ_VALID       (req_valid),
        .REQ_WR          (req_wr),
        .REQ_ADDR        (req_addr),
        .REQ_WDATA       (req_wdata),
        .REQ_READY       (req_ready),
        .RSP_VALID       (rsp_valid),
        .RSP_RDATA       (rsp_rdata),
        .RSP_ERR         (rsp_err),
        .NATIVE_CLK      (native_clk),
        .NATIVE_EN       (native_en),
        .NATIVE_WR       (native_wr),
        .NATIVE_ADDR     (native_addr),
        .NATIVE_DATA_IN  (native_data_in),
        .NATIVE_DATA_OUT (native_data_out),
        .NATIVE_READY    (native_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Simple slave: READY for one cycle, slave_lat cycles after the strobe; 0 = never.
    int            slave_lat = 1;
    int            slave_cd = 0;
    logic [DW-1:0] slave_rdata = '0;
    assign native_data_out = slave_rdata;

    always @(posedge clk) begin
        #1;
        native_ready = 1'b0;
        if (!rst_n) begin
            slave_cd = 0;
        end else begin
            if (slave_cd > 0) begin
                slave_cd--;
                if (slave_cd == 0) native_ready = 1'b1;
            end
            if (native_en && slave_lat > 0) slave_cd = slave_lat;
        end
    end

    // Event recorder used by the directed checks.
    int            en_cnt = 0;
    int            en_cyc_last = 0;
    logic          en_wr_last = 1'b0;
    logic [AW-1:0] en_addr_last = '0;
    logic [DW-1:0] en_data_last = '0;
    int            en_q[$];
    logic [N-1:0]  gr_q[$];
    int            rsp_cnt = 0;
    int            rsp_cyc_last = 0;
    logic [N-1:0]  rsp_vec_last = '0;
    logic [DW-1:0] rsp_data_last = '0;
    logic          rsp_err_last = 1'b0;

    always @(negedge clk) begin
        if (native_en === 1'b1) begin
            en_cnt++;
            en_cyc_last  = cyc;
            en_wr_last   = native_wr;
            en_addr_last = native_addr;
            en_data_last = native_data_in;
            en_q.push_back(cyc);
        end
        if (req_ready != '0) gr_q.push_back(req_ready);
        if (rsp_valid != '0) begin
            rsp_cnt++;
            rsp_cyc_last  = cyc;
            rsp_vec_last  = rsp_valid;
            rsp_data_last = rsp_rdata;
            rsp_err_last  = rsp_err;
        end
    end

    // Transaction-level reference: timestamps of grant, strobe and completion.
    bit            m_active = 0;
    bit            m_sched = 0;
    bit            m_have = 0;
    int            m_ptr = 0;
    int            m_grant = 0;
    int            m_issue = -1;
    int            m_wait = -1;
    int            m_rsp = -1;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0; m_sched = 0; m_have = 0; m_ptr = 0;
            m_issue = -1; m_wait = -1; m_rsp = -1;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_native_en", native_en, 0);
            chk("rst_native_wr", native_wr, 0);
            chk("rst_native_addr", native_addr, 0);
            chk("rst_native_data", native_data_in, 0);
        end else begin
            chk("m_req_ready", req_ready, (cyc == m_issue) ? (64'd1 << m_grant) : 64'd0);
            chk("m_native_en", native_en, (cyc == m_issue) ? 64'd1 : 64'd0);
            chk("m_rsp_valid", rsp_valid, (cyc == m_rsp) ? (64'd1 << m_grant) : 64'd0);
            if (cyc == m_rsp) begin
                chk("m_rsp_rdata", rsp_rdata, m_rdata);
                chk("m_rsp_err", rsp_err, m_err);
            end
            chk("m_native_wr", native_wr, m_have ? m_wr : 1'b0);
            chk("m_native_addr", native_addr, m_have ? m_addr : '0);
            chk("m_native_data", native_data_in, m_have ? m_wdata : '0);

            if (m_active && m_sched && cyc == m_rsp) begin
                m_active = 0;
                m_ptr = (m_grant + 1) % N;
            end else if (m_active && !m_sched && cyc >= m_wait) begin
                if (native_ready) begin
                    m_sched = 1; m_rsp = cyc + 1; m_err = 1'b0;
                    m_rdata = m_wr ? '0 : native_data_out;
                end
`ifdef NATIVE_ARB_TIMEOUT_EN
                else if (cyc - m_wait + 1 == TO) begin
                    m_sched = 1; m_rsp = cyc + 1; m_err = 1'b1; m_rdata = '0;
                end
`endif
            end else if (!m_active && req_valid != '0) begin
                for (int k = 0; k < N; k++) begin
                    int jj;
                    jj = (m_ptr + k) % N;
                    if (!m_active && req_valid[jj]) begin
                        m_active = 1; m_sched = 0; m_have = 1;
                        m_grant = jj;
                        m_wr    = req_wr[jj];
                        m_addr  = req_addr[jj*AW +: AW];
                        m_wdata = req_wdata[jj*DW +: DW];
                        m_issue = cyc + 1;
                        m_wait  = cyc + 2;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]             = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic request(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        set_req(i, wr, a, d);
        req_valid[i] = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!req_ready[i] && k < 30);
        chk($sformatf("granted_%0d", i), req_ready[i], 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int k;
        k = 0;
        while (rsp_cnt < target && k < budget) begin
            step();
            k++;
        end
        chk("rsp_arrived", rsp_cnt >= target, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    int n0;
    int e0;

    initial begin
        #1;
        chk("init_native_en", native_en, 0);
        chk("init_rsp_valid", rsp_valid, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single read: requester 0, addr 3, slave ready two cycles after the strobe.
        slave_lat = 2; slave_rdata = 32'hA5A5_0001; n0 = rsp_cnt;
        request(0, 1'b0, 4'd3, 32'h0);
        wait_rsp(n0 + 1, 30);
        chk("rd_wr", en_wr_last, 0);
        chk("rd_addr", en_addr_last, 3);
        chk("rd_latency", rsp_cyc_last - en_cyc_last, 3);
        chk("rd_vec", rsp_vec_last, 2'b01);
        chk("rd_data", rsp_data_last, 32'hA5A5_0001);
        step();

        // Single write: requester 1, 0x1234 to addr 5, slave ready right after the strobe.
        slave_lat = 1; slave_rdata = 32'hDEAD_BEEF; n0 = rsp_cnt;
        request(1, 1'b1, 4'd5, 32'h1234);
        wait_rsp(n0 + 1, 30);
        chk("wr_wr", en_wr_last, 1);
        chk("wr_addr", en_addr_last, 5);
        chk("wr_data_in", en_data_last, 32'h1234);
        chk("wr_latency", rsp_cyc_last - en_cyc_last, 2);
        chk("wr_vec", rsp_vec_last, 2'b10);
        chk("wr_rdata", rsp_data_last, 0);
        step();

        // Contention: both valid continuously for four transactions.
        slave_lat = 1; slave_rdata = 32'h0000_0777; n0 = rsp_cnt;
        en_q.delete(); gr_q.delete();
        set_req(0, 1'b0, 4'd1, 32'h0);
        set_req(1, 1'b1, 4'd2, 32'h55);
        req_valid = 2'b11;
        e0 = 0;
        while (gr_q.size() < 4 && e0 < 60) begin step(); e0++; end
        req_valid = 2'b00;
        wait_rsp(n0 + 4, 40);
        chk("ct_grants", gr_q.size(), 4);
        chk("ct_strobes", en_q.size(), 4);
        if (gr_q.size() == 4 && en_q.size() == 4) begin
            chk("ct_g0", gr_q[0], 2'b01);
            chk("ct_g1", gr_q[1], 2'b10);
            chk("ct_g2", gr_q[2], 2'b01);
            chk("ct_g3", gr_q[3], 2'b10);
            for (int i = 0; i < 3; i++)
                chk($sformatf("ct_gap%0d", i), en_q[i+1] - en_q[i], 4);
        end
        step();

        // Withdrawal: requester 1 drops valid while requester 0 is in WAIT.
        slave_lat = 3; slave_rdata = 32'h0000_0707; n0 = rsp_cnt; e0 = en_cnt;
        gr_q.delete();
        set_req(0, 1'b0, 4'd7, 32'h0);
        set_req(1, 1'b0, 4'd8, 32'h0);
        req_valid = 2'b11;
        begin
            int k;
            k = 0;
            do begin step(); k++; end while (!req_ready[0] && k < 30);
            chk("wd_granted_0", req_ready, 2'b01);
        end
        req_valid[0] = 1'b0;
        step();
        req_valid[1] = 1'b0;
        wait_rsp(n0 + 1, 30);
        repeat (10) step();
        chk("wd_strobes", en_cnt - e0, 1);
        chk("wd_grants", gr_q.size(), 1);
        chk("wd_data", rsp_data_last, 32'h0000_0707);

`ifdef NATIVE_ARB_TIMEOUT_EN
        // Timeout: slave never ready; requester 1 is next in turn.
        slave_lat = 0; slave_rdata = 32'hBAD0_BAD0; n0 = rsp_cnt;
        request(1, 1'b0, 4'd4, 32'h0);
        wait_rsp(n0 + 1, 40);
        chk("to_latency", rsp_cyc_last - en_cyc_last, 9);
        chk("to_err", rsp_err_last, 1);
        chk("to_rdata", rsp_data_last, 0);
        chk("to_vec", rsp_vec_last, 2'b10);
        step();

        // Ready on the same cycle the timeout would fire: ready wins.
        slave_lat = 8; slave_rdata = 32'hC0DE_0008; n0 = rsp_cnt;
        request(0, 1'b0, 4'd6, 32'h0);
        wait_rsp(n0 + 1, 40);
        chk("tr_latency", rsp_cyc_last - en_cyc_last, 9);
        chk("tr_err", rsp_err_last, 0);
        chk("tr_rdata", rsp_data_last, 32'hC0DE_0008);
        step();
`endif

        // Reset during WAIT: requester 1 holds the port, slave never answers.
        slave_lat = 0;
        request(1, 1'b1, 4'd9, 32'hFACE_0009);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("arst_native_addr", native_addr, 0);
        chk("arst_native_data", native_data_in, 0);
        chk("arst_native_wr", native_wr, 0);
        chk("arst_native_en", native_en, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        n0 = rsp_cnt;
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("arst_no_rsp", rsp_cnt, n0);

        slave_lat = 1; slave_rdata = 32'h0000_00AB; gr_q.delete();
        set_req(0, 1'b0, 4'd10, 32'h0);
        set_req(1, 1'b0, 4'd11, 32'h0);
        req_valid = 2'b11;
        e0 = 0;
        while (gr_q.size() < 1 && e0 < 30) begin step(); e0++; end
        req_valid = 2'b00;
        wait_rsp(n0 + 1, 30);
        chk("arst_first_grants", gr_q.size(), 1);
        if (gr_q.size() == 1) chk("arst_first_is_0", gr_q[0], 2'b01);
        chk("arst_rsp_vec", rsp_vec_last, 2'b01);
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/native_port_arbiter.md
# native_port_arbiter

Shares one native register port among `NUM_REQ` requesters, such as an AXI-to-native bridge and on-chip sequencers, using round-robin arbitration. It serialises transactions so that exactly one request is outstanding on the native port at a time. For each request it issues a one-cycle `NATIVE_EN` strobe, waits for `NATIVE_READY`, and returns read data or a write completion to the granted requester. It sits between the requesters and the register-file or delay-line native slave, in the `S_AXI_aclk` domain.

## Interface
- `NUM_REQ`, 2: number of requesters; must be ≥2.
- `NATIVE_ADDR_WIDTH`, 4: native address width.
- `NATIVE_DATA_WIDTH`, 32: native data width.
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before error completion; only used with the timeout macro.
- `S_AXI_aclk`  in  1  the single clock.
- `S_AXI_aresetn`  in  1  reset, asynchronous and active-low.
- `REQ_VALID`  in  NUM_REQ  per-requester request valid.
- `REQ_WR`  in  NUM_REQ  1 = write, 0 = read.
- `REQ_ADDR`  in  NUM_REQ*NATIVE_ADDR_WIDTH  packed addresses; requester i occupies slice i.
- `REQ_WDATA`  in  NUM_REQ*NATIVE_DATA_WIDTH  packed write data.
- `REQ_READY`  out  NUM_REQ  one-cycle acceptance pulse.
- `RSP_VALID`  out  NUM_REQ  one-cycle completion pulse.
- `RSP_RDATA`  out  NATIVE_DATA_WIDTH  read data; qualified by `RSP_VALID`.
- `RSP_ERR`  out  1  timeout error flag; qualified by `RSP_VALID`.
- `NATIVE_CLK`  out  1  equals `S_AXI_aclk`.
- `NATIVE_EN`  out  1  one-cycle access strobe.
- `NATIVE_WR`  out  1  transaction direction.
- `NATIVE_ADDR`  out  NATIVE_ADDR_WIDTH  address.
- `NATIVE_DATA_IN`  out  NATIVE_DATA_WIDTH  write data.
- `NATIVE_DATA_OUT`  in  NATIVE_DATA_WIDTH  read data from the slave.
- `NATIVE_READY`  in  1  completion from the slave.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if `REQ_VALID` is nonzero, pick the first set bit at or after `ptr`, cyclically.
  - Latch `grant`, and latch that requester's wr, addr and wdata into the `NATIVE_*` registers.
  - Pulse `REQ_READY[grant]` and go to ISSUE.
- ISSUE: `NATIVE_EN`=1 for exactly this cycle. `NATIVE_READY` is ignored. Go to WAIT.
- WAIT: on `NATIVE_READY`=1:
  - Register `RSP_RDATA` = `NATIVE_DATA_OUT` for a read, 0 for a write.
  - Register `RSP_ERR`=0 and `RSP_VALID[grant]`=1.
  - Go to RESP.
- RESP: the `RSP_VALID` pulse is visible this cycle. Set `ptr` = (grant+1) mod NUM_REQ. Go to IDLE.
- `NATIVE_WR`, `NATIVE_ADDR` and `NATIVE_DATA_IN` hold from ISSUE until the next grant.
- Requester rules:
  - `REQ_*` fields stay stable while `REQ_VALID` is high and before `REQ_READY`.
  - Deasserting `REQ_VALID` before acceptance is legal and drops the request.
  - After `REQ_READY`, the requester may present its next request. That request cannot be granted before IDLE.
- All outputs reset to 0. `ptr` resets to 0, giving requester 0 priority first.
- Reset mid-transaction drops it: no `RSP_VALID`, and the FSM returns to IDLE.

## Timing
- Request seen in IDLE at cycle T:
  - `REQ_READY` and `NATIVE_EN` are high at T+1.
  - `NATIVE_READY` is sampled from T+2 onward.
- `NATIVE_READY` seen at cycle W: `RSP_VALID` is high at W+1, and IDLE is at W+2.
- Minimum transaction is 4 cycles, so back-to-back `NATIVE_EN` strobes are 4 cycles apart.
- `NATIVE_READY` asserted during IDLE, ISSUE or RESP is ignored.

## Configuration
- `NATIVE_ARB_TIMEOUT_EN`, when defined:
  - A WAIT counter starts at 0 on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `NATIVE_READY`, the FSM completes with `RSP_ERR`=1, `RSP_RDATA`=0, and goes to RESP as normal.
  - If `NATIVE_READY` and the timeout occur in the same cycle, `NATIVE_READY` wins and `RSP_ERR`=0.
- When not defined: no counter exists, WAIT holds indefinitely, and `RSP_ERR` is tied to 0.

## Structure
- `native_arb_pkg` holds:
  - the state enum: IDLE, ISSUE, WAIT, RESP;
  - the `PTR_W` = $clog2(NUM_REQ) helper;
  - the timeout counter width function.
- Sub-module `native_rr_pick`: combinational round-robin picker. Inputs are the request vector and `ptr`; outputs are a one-hot grant, an index and `any`.

## Test plan
- Single read, NUM_REQ=2: requester 0 reads addr 3; slave returns 0xA5A5_0001 with `NATIVE_READY` at T+3 → `NATIVE_EN` at T+1 with WR=0, `RSP_VALID[0]` at T+4, `RSP_RDATA`=0xA5A5_0001.
- Single write: requester 1 writes 0x1234 to addr 5; slave is ready at T+2 → `NATIVE_DATA_IN`=0x1234, `NATIVE_WR`=1, `RSP_VALID[1]` at T+3, `RSP_RDATA`=0.
- Contention: both requesters hold valid continuously for 4 transactions → grant order 0, 1, 0, 1, with `NATIVE_EN` strobes exactly 4 cycles apart when the slave is ready immediately.
- Withdrawal: requester 1 drops valid while requester 0 is in WAIT → after completion no grant is made to 1 and the FSM stays IDLE.
- Timeout (macro on, TIMEOUT_CYCLES=8): slave never readies → `RSP_VALID` with `RSP_ERR`=1 and `RSP_RDATA`=0, at 8 WAIT cycles plus 1. A second run with `NATIVE_READY` in the same cycle as the timeout gives `RSP_ERR`=0.
- Reset during WAIT: assert `S_AXI_aresetn`=0 → all outputs are 0 immediately, no `RSP_VALID` follows, and the next request goes to requester 0 first.
